cell_stim_checker: RTL and testbench
====================================

Name: cell_stim_checker

Overview:
- Exhaustive stimulus/response tester for one 2-input standard cell under test (CUT) on the testwafer.
- Sits directly upstream and downstream of the CUT: drives its A/A1 inputs, captures its Y output, and compares Y against an expected truth table.
- Pass/fail counts and a per-vector failure mask go to the user-project wrapper, which exposes them on logic-analyzer or IO pins.

Parameters:
SETTLE_CYCLES, 4, cycles to wait after applying a vector before sampling Y; legal minimum 2, covers synchroniser latency.
CNT_W, 16, width of the pass and fail counters.

Ports:
wb_clk_i  input  1  system clock
wb_rst_ni  input  1  reset; asynchronous assert, active-low
start_i  input  1  single-cycle start request; honoured only in IDLE
stop_i  input  1  abort request; honoured in any non-IDLE state
continuous_i  input  1  1 = repeat the 4-vector sweep until stop_i
truth_i  input  4  expected Y for input vector index {B,A}; bit n = expected Y for vector n
cell_y_i  input  1  CUT output, asynchronous to wb_clk_i
cell_a_o  output  1  drive to CUT input A (vector bit 0)
cell_b_o  output  1  drive to CUT input A1 (vector bit 1)
cell_oeb_o  output  2  pad output-enable for A/B drive pins, active-low; 2'b00 while busy, 2'b11 otherwise
busy_o  output  1  high in any state other than IDLE
done_o  output  1  one-cycle pulse at the end of a non-continuous sweep
pass_cnt_o  output  CNT_W  count of matching samples
fail_cnt_o  output  CNT_W  count of mismatching samples
fail_mask_o  output  4  sticky; bit n set if vector n ever mismatched

Behaviour:
- Reset values (async, wb_rst_ni=0):
  - state IDLE; cell_a_o=0, cell_b_o=0, cell_oeb_o=2'b11, busy_o=0, done_o=0.
  - Counters 0, fail_mask_o=0, vector index 0, sync flops 0.
- Synchroniser: cell_y_i passes through 2 flops running continuously; the comparison uses the second flop (y_s).
- States: IDLE, DRIVE, WAIT, SAMPLE, DONE.
- IDLE: on start_i=1:
  - latch truth_i into truth_q and continuous_i into cont_q;
  - clear pass_cnt, fail_cnt and fail_mask; set vec=0; go to DRIVE.
- DRIVE (1 cycle):
  - register cell_a_o=vec[0], cell_b_o=vec[1];
  - load wait counter with SETTLE_CYCLES; go to WAIT.
- WAIT: decrement the counter each cycle; after SETTLE_CYCLES cycles in WAIT, go to SAMPLE.
- SAMPLE (1 cycle), compare y_s with truth_q[vec]:
  - match: pass_cnt+1; mismatch: fail_cnt+1 and fail_mask[vec]<=1.
  - Both counters saturate at all-ones, with no wrap.
  - If vec!=3: vec+1, go to DRIVE.
  - If vec==3 and cont_q=1: vec=0, go to DRIVE; counters and mask keep accumulating.
  - If vec==3 and cont_q=0: go to DONE.
- DONE (1 cycle): done_o=1 combinationally from state; next state IDLE.
- Timing:
  - Each vector takes SETTLE_CYCLES+2 cycles.
  - done_o is high in the cycle beginning 4*(SETTLE_CYCLES+2) edges after the edge that sampled start_i. Default: 24.
- stop_i in DRIVE/WAIT/SAMPLE/DONE:
  - next edge goes to IDLE; cell_a_o=cell_b_o=0; no done_o pulse.
  - Counters and mask hold their values, including any update from a SAMPLE coincident with stop_i.
  - stop_i takes priority over every transition except reset.
- start_i while busy: ignored. start_i and stop_i together in IDLE: start wins.
- truth_i and continuous_i changes during a run: no effect until the next start.
- Reset mid-sweep: immediate return to reset values; counters cleared.
- Outputs cell_a_o/cell_b_o: registered and glitch-free; they change only on DRIVE entry, on stop, or on reset.

Test Plan:
- NOR2 model (Y = ~(A|B)), truth_i=4'b0001, start pulse -> done_o pulse exactly 24 cycles after start; pass_cnt=4, fail_cnt=0, fail_mask=0000; A/B sequence 00,10,01,11 ({B,A} = 00,01,10,11).
- CUT stuck-at-0, truth_i=4'b0001 -> fail_cnt=1, pass_cnt=3, fail_mask=4'b0001; done_o at cycle 24.
- continuous_i=1, good NOR2, stop_i asserted after 3 full sweeps (72 cycles) -> pass_cnt=12, no done_o pulse, busy_o falls next cycle, A/B return to 0.
- CNT_W=3, continuous run of 3 sweeps -> pass_cnt saturates at 7 and stays there.
- start_i re-pulsed at cycle 10 of a run -> ignored; done_o still at cycle 24, counts unchanged versus the single-start run.
- wb_rst_ni low at cycle 15 -> all outputs immediately at reset values; a fresh start after release behaves as the first scenario.

Source files
------------

// File: rtl/cell_stim_checker_if.sv
// Control/status bundle between the user-project wrapper and the cell stimulus checker.
interface cell_stim_checker_if #(
    parameter int CNT_W = 16
) ();
    logic             start_i;
    logic             stop_i;
    logic             continuous_i;
    logic [3:0]       truth_i;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] pass_cnt_o;
    logic [CNT_W-1:0] fail_cnt_o;
    logic [3:0]       fail_mask_o;

    modport master (
        output start_i, stop_i, continuous_i, truth_i,
        input  busy_o, done_o, pass_cnt_o, fail_cnt_o, fail_mask_o
    );

    modport slave (
        input  start_i, stop_i, continuous_i, truth_i,
        output busy_o, done_o, pass_cnt_o, fail_cnt_o, fail_mask_o
    );
endinterface

// File: rtl/cell_stim_checker.sv
// Exhaustive 4-vector stimulus/response tester for one 2-input cell: drives {B,A},
// waits for the synchronised Y to settle, compares against a latched truth table.
module cell_stim_checker #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                cell_y_i,
    output logic                cell_a_o,
    output logic                cell_b_o,
    output logic [1:0]          cell_oeb_o,
    cell_stim_checker_if.slave  ctrl
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DRIVE  = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] SAMPLE = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam int               WAIT_W  = (SETTLE_CYCLES < 2) ? 2 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]       state_q,    state_d;
    logic [1:0]       vec_q,      vec_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic [3:0]       truth_q,    truth_d;
    logic             cont_q,     cont_d;
    logic [CNT_W-1:0] passCnt_q,  passCnt_d;
    logic [CNT_W-1:0] failCnt_q,  failCnt_d;
    logic [3:0]       failMask_q, failMask_d;
    logic             cellA_q,    cellA_d;
    logic             cellB_q,    cellB_d;
    logic             yMeta_q;
    logic             ySync_q;

    // Y comes from the CUT with no timing relation to our clock; two-flop synchroniser.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            yMeta_q <= 1'b0;
            ySync_q <= 1'b0;
        end else begin
            yMeta_q <= cell_y_i;
            ySync_q <= yMeta_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        waitCnt_d  = waitCnt_q;
        truth_d    = truth_q;
        cont_d     = cont_q;
        passCnt_d  = passCnt_q;
        failCnt_d  = failCnt_q;
        failMask_d = failMask_q;
        cellA_d    = cellA_q;
        cellB_d    = cellB_q;

        case (state_q)
            IDLE: begin
                if (ctrl.start_i) begin
                    truth_d    = ctrl.truth_i;
                    cont_d     = ctrl.continuous_i;
                    passCnt_d  = '0;
                    failCnt_d  = '0;
                    failMask_d = '0;
                    vec_d      = 2'd0;
                    cellA_d    = 1'b0;
                    cellB_d    = 1'b0;
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                waitCnt_d = WAIT_W'(SETTLE_CYCLES);
                state_d   = WAIT;
            end
            WAIT: begin
                waitCnt_d = waitCnt_q - WAIT_W'(1);
                if (waitCnt_q == WAIT_W'(1)) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (ySync_q == truth_q[vec_q]) begin
                    if (passCnt_q != CNT_MAX) passCnt_d = passCnt_q + 1'b1;
                end else begin
                    if (failCnt_q != CNT_MAX) failCnt_d = failCnt_q + 1'b1;
                    failMask_d[vec_q] = 1'b1;
                end
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    state_d = DRIVE;
                end else if (cont_q) begin
                    vec_d   = 2'd0;
                    state_d = DRIVE;
                end else begin
                    state_d = DONE;
                end
                // Pins update only as we enter DRIVE, so they are stable for the whole vector.
                if (state_d == DRIVE) begin
                    cellA_d = vec_d[0];
                    cellB_d = vec_d[1];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides the sequencing but not a coincident SAMPLE update of the counters.
        if ((state_q != IDLE) && ctrl.stop_i) begin
            state_d = IDLE;
            cellA_d = 1'b0;
            cellB_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= IDLE;
            vec_q      <= 2'd0;
            waitCnt_q  <= '0;
            truth_q    <= 4'd0;
            cont_q     <= 1'b0;
            passCnt_q  <= '0;
            failCnt_q  <= '0;
            failMask_q <= 4'd0;
            cellA_q    <= 1'b0;
            cellB_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            waitCnt_q  <= waitCnt_d;
            truth_q    <= truth_d;
            cont_q     <= cont_d;
            passCnt_q  <= passCnt_d;
            failCnt_q  <= failCnt_d;
            failMask_q <= failMask_d;
            cellA_q    <= cellA_d;
            cellB_q    <= cellB_d;
        end
    end

    assign cell_a_o         = cellA_q;
    assign cell_b_o         = cellB_q;
    assign ctrl.busy_o      = (state_q != IDLE);
    assign ctrl.done_o      = (state_q == DONE);
    assign cell_oeb_o       = (state_q != IDLE) ? 2'b00 : 2'b11;
    assign ctrl.pass_cnt_o  = passCnt_q;
    assign ctrl.fail_cnt_o  = failCnt_q;
    assign ctrl.fail_mask_o = failMask_q;

endmodule

// File: tb/tb_cell_stim_checker.sv
// Scoreboard bench for cell_stim_checker: a NOR2 / stuck-at-0 CUT model drives Y,
// expected vectors and sweep results are queued at start and popped as the DUT produces them.
module tb_cell_stim_checker;

    localparam int SETTLE  = 4;
    localparam int VEC_CYC = SETTLE + 2;

    typedef struct {
        int         passCnt;
        int         failCnt;
        logic [3:0] mask;
    } result_t;

    logic       clk = 1'b0;
    logic       rstN;
    logic       cellY, cellA, cellB;
    logic [1:0] cellOeb;
    logic       satY, satA, satB;
    logic [1:0] satOeb;
    bit         stuckLow;

    result_t    resQ[$];
    logic [1:0] vecQ[$];
    int         checks = 0;
    int         errors = 0;
    int         doneAt;
    int         doneCount;

    always #5 clk = ~clk;

    cell_stim_checker_if #(.CNT_W(16)) dutIf ();
    cell_stim_checker_if #(.CNT_W(3))  satIf ();

    assign satIf.start_i      = dutIf.start_i;
    assign satIf.stop_i       = dutIf.stop_i;
    assign satIf.continuous_i = dutIf.continuous_i;
    assign satIf.truth_i      = dutIf.truth_i;

    // CUT models: good NOR2 or output stuck low.
    assign cellY = stuckLow ? 1'b0 : ~(cellA | cellB);
    assign satY  = stuckLow ? 1'b0 : ~(satA | satB);

    cell_stim_checker #(.SETTLE_CYCLES(SETTLE), .CNT_W(16)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rstN),
        .cell_y_i   (cellY),
        .cell_a_o   (cellA),
        .cell_b_o   (cellB),
        .cell_oeb_o (cellOeb),
        .ctrl       (dutIf)
    );

    cell_stim_checker #(.SETTLE_CYCLES(SETTLE), .CNT_W(3)) satDut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rstN),
        .cell_y_i   (satY),
        .cell_a_o   (satA),
        .cell_b_o   (satB),
        .cell_oeb_o (satOeb),
        .ctrl       (satIf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic result_t predict(input logic [3:0] truth, input bit stuck);
        result_t r;
        logic    y;
        r.passCnt = 0;
        r.failCnt = 0;
        r.mask    = 4'b0000;
        for (int v = 0; v < 4; v++) begin
            y = stuck ? 1'b0 : (v == 0);
            if (y == truth[v]) r.passCnt++;
            else begin
                r.failCnt++;
                r.mask[v] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic [3:0] truth, input bit cont, input bit stuck,
                                 input bit withStop, input int sweeps);
        stuckLow           = stuck;
        dutIf.truth_i      = truth;
        dutIf.continuous_i = cont;
        dutIf.stop_i       = withStop;
        dutIf.start_i      = 1'b1;
        for (int s = 0; s < sweeps; s++)
            for (int v = 0; v < 4; v++) vecQ.push_back(v[1:0]);
        if (!cont) resQ.push_back(predict(truth, stuck));
        @(posedge clk); #1;
        dutIf.start_i      = 1'b0;
        dutIf.stop_i       = 1'b0;
        // Scramble configuration mid-run; the DUT must keep its latched copy.
        dutIf.truth_i      = ~truth;
        dutIf.continuous_i = ~cont;
    endtask

    task automatic runAndWatch(input int cycles, input int pulseAt);
        result_t r;
        doneAt    = -1;
        doneCount = 0;
        for (int k = 1; k <= cycles; k++) begin
            @(posedge clk); #1;
            if ((k % VEC_CYC == VEC_CYC - 1) && (vecQ.size() > 0)) begin
                checkOutput("vecBA", 32'({cellB, cellA}), 32'(vecQ.pop_front()));
                checkOutput("oebBusy", 32'(cellOeb), 32'd0);
            end
            if (dutIf.done_o) begin
                doneCount++;
                if (doneAt < 0) doneAt = k;
                if (resQ.size() > 0) begin
                    r = resQ.pop_front();
                    checkOutput("passCnt", 32'(dutIf.pass_cnt_o), 32'(r.passCnt));
                    checkOutput("failCnt", 32'(dutIf.fail_cnt_o), 32'(r.failCnt));
                    checkOutput("failMask", 32'(dutIf.fail_mask_o), 32'(r.mask));
                end
            end
            if (k == pulseAt) dutIf.start_i = 1'b1;
            else if (k == pulseAt + 1) dutIf.start_i = 1'b0;
        end
    endtask

    task automatic checkIdle(input string tag, input int expPass, input int expFail, input logic [3:0] expMask);
        checkOutput({tag, "Busy"}, 32'(dutIf.busy_o), 32'd0);
        checkOutput({tag, "Done"}, 32'(dutIf.done_o), 32'd0);
        checkOutput({tag, "Oeb"}, 32'(cellOeb), 32'd3);
        checkOutput({tag, "BA"}, 32'({cellB, cellA}), 32'd0);
        checkOutput({tag, "Pass"}, 32'(dutIf.pass_cnt_o), 32'(expPass));
        checkOutput({tag, "Fail"}, 32'(dutIf.fail_cnt_o), 32'(expFail));
        checkOutput({tag, "Mask"}, 32'(dutIf.fail_mask_o), 32'(expMask));
    endtask

    task automatic finishSingleRun(input string tag);
        checkOutput({tag, "DoneAt"}, 32'(doneAt), 32'd24);
        checkOutput({tag, "DoneCount"}, 32'(doneCount), 32'd1);
        checkOutput({tag, "ResLeft"}, 32'(resQ.size()), 32'd0);
        checkOutput({tag, "VecLeft"}, 32'(vecQ.size()), 32'd0);
        checkOutput({tag, "BusyAfter"}, 32'(dutIf.busy_o), 32'd0);
        resQ.delete();
        vecQ.delete();
    endtask

    initial begin
        rstN               = 1'b0;
        stuckLow           = 1'b0;
        dutIf.start_i      = 1'b0;
        dutIf.stop_i       = 1'b0;
        dutIf.continuous_i = 1'b0;
        dutIf.truth_i      = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        checkIdle("reset", 0, 0, 4'b0000);
        checkOutput("resetSatOeb", 32'(satOeb), 32'd3);
        rstN = 1'b1;
        @(posedge clk); #1;

        $display("[TB] good NOR2 single sweep");
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1);
        runAndWatch(30, -1);
        finishSingleRun("nor");
        checkOutput("norSatPass", 32'(satIf.pass_cnt_o), 32'd4);

        $display("[TB] stuck-at-0 CUT, start and stop together");
        applyStimulus(4'b0001, 1'b0, 1'b1, 1'b1, 1);
        runAndWatch(30, -1);
        finishSingleRun("stuck");

        $display("[TB] continuous run stopped after three sweeps");
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 3);
        runAndWatch(72, -1);
        checkOutput("contDoneCount", 32'(doneCount), 32'd0);
        checkOutput("contBusy", 32'(dutIf.busy_o), 32'd1);
        checkOutput("contVecLeft", 32'(vecQ.size()), 32'd0);
        checkOutput("satPass", 32'(satIf.pass_cnt_o), 32'd7);
        dutIf.stop_i = 1'b1;
        @(posedge clk); #1;
        dutIf.stop_i = 1'b0;
        checkIdle("stop", 12, 0, 4'b0000);
        runAndWatch(6, -1);
        checkOutput("stopNoDone", 32'(doneCount), 32'd0);
        checkOutput("stopPassHeld", 32'(dutIf.pass_cnt_o), 32'd12);
        checkOutput("satPassHeld", 32'(satIf.pass_cnt_o), 32'd7);
        checkOutput("satFail", 32'(satIf.fail_cnt_o), 32'd0);
        vecQ.delete();

        $display("[TB] start re-pulsed mid-run");
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1);
        runAndWatch(30, 10);
        finishSingleRun("repulse");

        $display("[TB] reset mid-sweep then fresh run");
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1);
        runAndWatch(15, -1);
        checkOutput("preResetPass", 32'(dutIf.pass_cnt_o), 32'd2);
        rstN = 1'b0;
        #1;
        checkIdle("midReset", 0, 0, 4'b0000);
        vecQ.delete();
        resQ.delete();
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 1);
        runAndWatch(30, -1);
        finishSingleRun("afterReset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
